// File: rtl/filter_sweep_ctrl.sv
// Frequency-sweep sequencer: steps a sine period, resets and settles the filter
// chain, then measures peak-to-peak of the filter output for each point.
module filter_sweep_ctrl #(
  parameter int WORD_WIDTH   = 16,
  parameter int PERIOD_WIDTH = 32,
  parameter int CNT_WIDTH    = 32,
  parameter int RESET_CYCLES = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic                    abort,
  input  logic [PERIOD_WIDTH-1:0] period_start,
  input  logic [PERIOD_WIDTH-1:0] period_step,
  input  logic [PERIOD_WIDTH-1:0] period_stop,
  input  logic [CNT_WIDTH-1:0]    settle_cycles,
  input  logic [CNT_WIDTH-1:0]    measure_cycles,
  input  logic [WORD_WIDTH-1:0]   sample_in,
  input  logic                    sample_valid,
  output logic [PERIOD_WIDTH-1:0] period_out,
  output logic                    dut_rst_n,
  output logic                    result_valid,
  input  logic                    result_ready,
  output logic [PERIOD_WIDTH-1:0] result_period,
  output logic [WORD_WIDTH-1:0]   result_max,
  output logic [WORD_WIDTH-1:0]   result_min,
  output logic [WORD_WIDTH-1:0]   result_p2p,
  output logic                    busy,
  output logic                    done
);

  typedef enum logic [2:0] {IDLE, RST_DUT, SETTLE, MEASURE, REPORT, NEXT, FIN} state_t;

  state_t                  state_reg, state_next;
  logic [CNT_WIDTH-1:0]    cnt_reg, settle_reg, measure_reg;
  logic [CNT_WIDTH:0]      cnt_inc;
  logic [PERIOD_WIDTH-1:0] period_reg, step_reg, stop_reg;
  logic [PERIOD_WIDTH:0]   sum_next;
  logic [WORD_WIDTH-1:0]   max_reg, min_reg, max_next, min_next;
  logic                    seen_reg, seen_next;
  logic [PERIOD_WIDTH-1:0] res_period_reg;
  logic [WORD_WIDTH-1:0]   res_max_reg, res_min_reg, res_p2p_reg;
  logic                    rst_last, settle_last, measure_last, sweep_end;

  always_comb begin
    cnt_inc      = {1'b0, cnt_reg} + {{CNT_WIDTH{1'b0}}, 1'b1};
    rst_last     = (cnt_reg == CNT_WIDTH'(RESET_CYCLES - 1));
    // Zero-length settle/measure windows collapse to a single cycle.
    settle_last  = (cnt_inc >= {1'b0, settle_reg});
    measure_last = (cnt_inc >= {1'b0, measure_reg});
    sum_next     = {1'b0, period_reg} + {1'b0, step_reg};
    sweep_end    = (step_reg == '0) || sum_next[PERIOD_WIDTH] ||
                   (sum_next[PERIOD_WIDTH-1:0] > stop_reg);
    max_next     = max_reg;
    min_next     = min_reg;
    seen_next    = seen_reg;
    if (sample_valid) begin
      seen_next = 1'b1;
      if (sample_in > max_reg) max_next = sample_in;
      if (sample_in < min_reg) min_next = sample_in;
    end
  end

  always_comb begin
    state_next   = state_reg;
    busy         = 1'b1;
    done         = 1'b0;
    dut_rst_n    = 1'b1;
    result_valid = 1'b0;
    case (state_reg)
      IDLE: begin
        busy      = 1'b0;
        dut_rst_n = 1'b0;
        if (start) state_next = RST_DUT;
      end
      RST_DUT: begin
        dut_rst_n = 1'b0;
        if (rst_last) state_next = SETTLE;
      end
      SETTLE:  if (settle_last) state_next = MEASURE;
      MEASURE: if (measure_last) state_next = REPORT;
      REPORT: begin
        result_valid = 1'b1;
        if (result_ready) state_next = NEXT;
      end
      NEXT: state_next = sweep_end ? FIN : RST_DUT;
      FIN: begin
        dut_rst_n  = 1'b0;
        done       = !abort;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
    if (abort && state_reg != IDLE) state_next = IDLE;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_reg      <= IDLE;
      cnt_reg        <= '0;
      settle_reg     <= '0;
      measure_reg    <= '0;
      period_reg     <= '0;
      step_reg       <= '0;
      stop_reg       <= '0;
      max_reg        <= '0;
      min_reg        <= '1;
      seen_reg       <= 1'b0;
      res_period_reg <= '0;
      res_max_reg    <= '0;
      res_min_reg    <= '0;
      res_p2p_reg    <= '0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= (state_next != state_reg || state_reg == IDLE) ? '0 : cnt_inc[CNT_WIDTH-1:0];

      if (state_reg == IDLE && state_next == RST_DUT) begin
        period_reg  <= period_start;
        step_reg    <= period_step;
        stop_reg    <= period_stop;
        settle_reg  <= settle_cycles;
        measure_reg <= measure_cycles;
      end else if (state_reg == NEXT && state_next == RST_DUT) begin
        period_reg <= sum_next[PERIOD_WIDTH-1:0];
      end

      // Running extremes are re-armed whenever we are outside the window.
      if (state_reg == MEASURE) begin
        max_reg  <= max_next;
        min_reg  <= min_next;
        seen_reg <= seen_next;
      end else begin
        max_reg  <= '0;
        min_reg  <= '1;
        seen_reg <= 1'b0;
      end

      if (state_reg == MEASURE && state_next == REPORT) begin
        res_period_reg <= period_reg;
        res_max_reg    <= seen_next ? max_next : '0;
        res_min_reg    <= seen_next ? min_next : '0;
        res_p2p_reg    <= seen_next ? (max_next - min_next) : '0;
      end
    end
  end

  assign period_out    = period_reg;
  assign result_period = res_period_reg;
  assign result_max    = res_max_reg;
  assign result_min    = res_min_reg;
  assign result_p2p    = res_p2p_reg;

endmodule

// File: tb/tb_filter_sweep_ctrl.sv
// Directed bench for filter_sweep_ctrl: expected results are queued at stimulus
// time and a negedge monitor pops them on every result handshake.
module tb_filter_sweep_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0;
  logic        abort = 1'b0;
  logic [31:0] period_start = '0, period_step = '0, period_stop = '0;
  logic [31:0] settle_cycles = '0, measure_cycles = '0;
  logic [15:0] sample_in = '0;
  logic        sample_valid = 1'b0;
  logic [31:0] period_out;
  logic        dut_rst_n;
  logic        result_valid;
  logic        result_ready = 1'b1;
  logic [31:0] result_period;
  logic [15:0] result_max, result_min, result_p2p;
  logic        busy, done;

  typedef struct {
    logic [31:0] period;
    logic [15:0] mx, mn, p2p;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   checks = 0;
  int   fails = 0;
  int   done_cnt = 0;
  int   exp_done = 0;

  filter_sweep_ctrl dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort),
    .period_start(period_start), .period_step(period_step), .period_stop(period_stop),
    .settle_cycles(settle_cycles), .measure_cycles(measure_cycles),
    .sample_in(sample_in), .sample_valid(sample_valid),
    .period_out(period_out), .dut_rst_n(dut_rst_n),
    .result_valid(result_valid), .result_ready(result_ready),
    .result_period(result_period), .result_max(result_max),
    .result_min(result_min), .result_p2p(result_p2p),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation still running, required termination");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
    end
  endtask

  always @(negedge clk) begin
    if (rst && result_valid && result_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        fails++;
        $display("FAIL unexpected_result: got period 0x%0h, required no result", result_period);
      end else begin
        mon_e = exp_q.pop_front();
        $display("result period=0x%0h max=0x%0h min=0x%0h p2p=0x%0h",
                 result_period, result_max, result_min, result_p2p);
        check("result_period", result_period, mon_e.period);
        check("result_max", result_max, mon_e.mx);
        check("result_min", result_min, mon_e.mn);
        check("result_p2p", result_p2p, mon_e.p2p);
      end
    end
    if (rst && done) done_cnt++;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [15:0] d);
    sample_valid = v;
    sample_in    = d;
    tick();
  endtask

  task automatic push(input logic [31:0] p, input logic [15:0] mx, input logic [15:0] mn,
                      input logic [15:0] p2p);
    exp_t e;
    e.period = p; e.mx = mx; e.mn = mn; e.p2p = p2p;
    exp_q.push_back(e);
  endtask

  // Returns one cycle after the edge that sampled start; config is then scrambled.
  task automatic launch(input logic [31:0] ps, input logic [31:0] st, input logic [31:0] sp,
                        input logic [31:0] se, input logic [31:0] me);
    period_start = ps; period_step = st; period_stop = sp;
    settle_cycles = se; measure_cycles = me;
    start = 1'b1;
    tick();
    start = 1'b0;
    period_start = 32'h1234_5678; period_step = 32'h1; period_stop = 32'hFFFF_FFFF;
    settle_cycles = 32'd7; measure_cycles = 32'd3;
  endtask

  task automatic wait_idle(input string name, input int limit);
    int n = 0;
    while ((busy || exp_q.size() != 0) && n < limit) begin
      tick();
      n++;
    end
    checks++;
    if (n >= limit) begin
      fails++;
      $display("FAIL %s_timeout: got busy=%0b pending=%0d after %0d cycles, required idle",
               name, busy, exp_q.size(), n);
    end
  endtask

  task automatic check_reset_outputs(input string name);
    check({name, "_period_out"}, period_out, 0);
    check({name, "_dut_rst_n"}, dut_rst_n, 0);
    check({name, "_result_valid"}, result_valid, 0);
    check({name, "_result_period"}, result_period, 0);
    check({name, "_result_vals"}, {result_max, result_min, result_p2p}, 0);
    check({name, "_busy_done"}, {busy, done}, 0);
  endtask

  initial begin
    // Reset state
    repeat (3) tick();
    check_reset_outputs("reset");
    rst = 1'b1;
    tick();

    // Nominal sweep: 36-cycle point pitch, window edges 15..34 (+36 per point)
    result_ready = 1'b1;
    launch(32'd2, 32'd5, 32'd12, 32'd10, 32'd20);
    for (int i = 0; i < 3; i++)
      push(32'(2 + 5 * i), 16'(34 + 36 * i), 16'(15 + 36 * i), 16'd19);
    for (int k = 1; k <= 120; k++) drive(1'b1, 16'(k));
    drive(1'b0, 16'h0);
    wait_idle("nominal", 200);
    exp_done++;
    check("nominal_done", done_cnt, exp_done);

    // Extremes with settle-edge exclusion; step=0 gives a single point
    launch(32'h40, 32'd0, 32'h40, 32'd10, 32'd20);
    push(32'h40, 16'h8000, 16'h0010, 16'h7FF0);
    for (int k = 1; k <= 36; k++) begin
      case (k)
        12:      drive(1'b1, 16'h0001);
        14:      drive(1'b1, 16'hFFFF);
        15:      drive(1'b1, 16'h0100);
        24:      drive(1'b1, 16'h8000);
        34:      drive(1'b1, 16'h0010);
        35:      drive(1'b1, 16'h0005);
        default: drive(1'b0, 16'hFFFF);
      endcase
    end
    wait_idle("extremes", 100);
    exp_done++;
    check("extremes_done", done_cnt, exp_done);

    // Backpressure, settle=0, start above stop
    result_ready = 1'b0;
    launch(32'd100, 32'd1, 32'd50, 32'd0, 32'd3);
    for (int k = 1; k <= 9; k++) begin
      case (k)
        5:       drive(1'b1, 16'h0FFF);
        6:       drive(1'b1, 16'h00AA);
        7:       drive(1'b1, 16'h0055);
        9:       drive(1'b1, 16'h0001);
        default: drive(1'b0, 16'h0000);
      endcase
    end
    for (int c = 0; c < 50; c++) begin
      check("bp_hold_result", {result_valid, result_max, result_min, result_p2p},
            {1'b1, 16'h00AA, 16'h0055, 16'h0055});
      check("bp_hold_period", {period_out, result_period}, {32'd100, 32'd100});
      tick();
    end
    push(32'd100, 16'h00AA, 16'h0055, 16'h0055);
    result_ready = 1'b1;
    wait_idle("backpressure", 50);
    exp_done++;
    check("bp_done", done_cnt, exp_done);

    // Carry out of the period adder; measure=0 gives a one-cycle window
    launch(32'hFFFF_FFF0, 32'h20, 32'hFFFF_FFFF, 32'd2, 32'd0);
    push(32'hFFFF_FFF0, 16'h0042, 16'h0042, 16'h0000);
    for (int k = 1; k <= 8; k++) begin
      case (k)
        6:       drive(1'b1, 16'h0001);
        7:       drive(1'b1, 16'h0042);
        8:       drive(1'b1, 16'h0003);
        default: drive(1'b0, 16'h0000);
      endcase
    end
    drive(1'b0, 16'h0);
    wait_idle("carry", 100);
    exp_done++;
    check("carry_done", done_cnt, exp_done);

    // Abort inside the measurement window
    launch(32'd3, 32'd0, 32'd3, 32'd2, 32'd10);
    for (int k = 1; k <= 9; k++) drive(1'b1, 16'h0077);
    abort = 1'b1;
    drive(1'b1, 16'h0077);
    abort = 1'b0;
    check("abort_state", {busy, dut_rst_n, result_valid}, 3'b000);
    for (int c = 0; c < 30; c++) drive(1'b0, 16'h0);
    check("abort_idle", busy, 0);
    check("abort_no_done", done_cnt, exp_done);

    // Clean sweep after abort with no valid samples
    launch(32'd9, 32'd0, 32'd9, 32'd1, 32'd5);
    push(32'd9, 16'h0, 16'h0, 16'h0);
    wait_idle("nosample", 100);
    exp_done++;
    check("nosample_done", done_cnt, exp_done);

    // Reset while a result is pending
    result_ready = 1'b0;
    launch(32'd5, 32'd0, 32'd5, 32'd0, 32'd0);
    for (int k = 1; k <= 8; k++) drive(1'b1, 16'h0033);
    drive(1'b0, 16'h0);
    check("rst_pre_report", {result_valid, result_max}, {1'b1, 16'h0033});
    rst = 1'b0;
    start = 1'b1;
    result_ready = 1'b1;
    tick();
    check_reset_outputs("rst_report");
    repeat (3) tick();
    check("rst_start_ignored", busy, 0);
    start = 1'b0;
    rst = 1'b1;
    repeat (5) tick();
    check("rst_release_idle", {busy, result_valid}, 2'b00);
    check("final_done", done_cnt, exp_done);
    check("final_queue", exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
